// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand fetch stage.
package operand_fetch_pkg;
  localparam int XLEN            = 32;
  localparam int REG_INDEX_WIDTH = 5;
  localparam logic [REG_INDEX_WIDTH-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FRESH = 2'd1,
    HELD  = 2'd2
  } of_state_e;
endpackage

// File: rtl/operand_slot.sv
// One operand: held index, same-edge bypass capture, held value and write snoop.
// OPERAND_FETCH_LIVE_BYPASS_EN forwards a write retiring this cycle onto value_o.
module operand_slot
  import operand_fetch_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       accept_i,
  input  logic                       latch_i,
  input  logic                       valid_i,
  input  logic                       held_i,
  input  logic [REG_INDEX_WIDTH-1:0] rs_i,
  input  logic [XLEN-1:0]            read_value_i,
  input  logic                       write_enabled_i,
  input  logic [REG_INDEX_WIDTH-1:0] write_index_i,
  input  logic [XLEN-1:0]            write_value_i,
  output logic [REG_INDEX_WIDTH-1:0] index_o,
  output logic [XLEN-1:0]            value_o
);
  logic [REG_INDEX_WIDTH-1:0] idx_q;
  logic                       byp_q;
  logic [XLEN-1:0]            byp_val_q;
  logic [XLEN-1:0]            val_q;
  logic                       hit_new, hit_held;
  logic [XLEN-1:0]            resolved;

  assign hit_new  = write_enabled_i && (write_index_i == rs_i)  && (rs_i  != ZERO_REG);
  assign hit_held = write_enabled_i && (write_index_i == idx_q) && (idx_q != ZERO_REG);

  // The file returns pre-write data for a read on the write edge, so the
  // captured write value wins over read_value_i in the first valid cycle.
  always_comb begin
    resolved = held_i ? val_q : (byp_q ? byp_val_q : read_value_i);
    if (!valid_i || idx_q == ZERO_REG) resolved = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q     <= ZERO_REG;
      byp_q     <= 1'b0;
      byp_val_q <= '0;
      val_q     <= '0;
    end else if (accept_i) begin
      idx_q     <= rs_i;
      byp_q     <= hit_new;
      byp_val_q <= hit_new ? write_value_i : '0;
    end else if (latch_i) begin
      val_q     <= hit_held ? write_value_i : resolved;
    end
  end

  assign index_o = idx_q;

`ifdef OPERAND_FETCH_LIVE_BYPASS_EN
  assign value_o = (valid_i && hit_held) ? write_value_i : resolved;
`else
  assign value_o = resolved;
`endif
endmodule

// File: rtl/operand_fetch.sv
// Single-stage operand fetch between decode and execute; hides the register
// file's 1-cycle read latency. Optional: OPERAND_FETCH_LIVE_BYPASS_EN.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int TAG_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REG_INDEX_WIDTH-1:0] in_rs1,
  input  logic [REG_INDEX_WIDTH-1:0] in_rs2,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  output logic [REG_INDEX_WIDTH-1:0] read_index_1,
  output logic [REG_INDEX_WIDTH-1:0] read_index_2,
  input  logic [XLEN-1:0]            read1_value,
  input  logic [XLEN-1:0]            read2_value,
  input  logic                       write_enabled,
  input  logic [REG_INDEX_WIDTH-1:0] write_index,
  input  logic [XLEN-1:0]            write_value,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_rs1_value,
  output logic [XLEN-1:0]            out_rs2_value,
  output logic [TAG_WIDTH-1:0]       out_tag
);
  of_state_e            state_q, state_d;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 accept, emit, latch, held;

  logic [1:0][REG_INDEX_WIDTH-1:0] rs, held_idx;
  logic [1:0][XLEN-1:0]            rd_val, op_val;

  assign out_valid = (state_q != EMPTY);
  assign held      = (state_q == HELD);
  assign in_ready  = !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  // Stalled this edge: operands must be frozen (with snoop) into the slots.
  assign latch     = out_valid && !out_ready && !flush;

  always_comb begin
    state_d = state_q;
    if (flush)          state_d = EMPTY;
    else if (accept)    state_d = FRESH;
    else if (emit)      state_d = EMPTY;
    else if (out_valid) state_d = HELD;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) tag_q <= in_tag;
    end
  end

  assign rs     = {in_rs2, in_rs1};
  assign rd_val = {read2_value, read1_value};

  for (genvar g = 0; g < 2; g++) begin : g_slot
    operand_slot u_slot (
      .clk             (clk),
      .reset_n         (reset_n),
      .accept_i        (accept),
      .latch_i         (latch),
      .valid_i         (out_valid),
      .held_i          (held),
      .rs_i            (rs[g]),
      .read_value_i    (rd_val[g]),
      .write_enabled_i (write_enabled),
      .write_index_i   (write_index),
      .write_value_i   (write_value),
      .index_o         (held_idx[g]),
      .value_o         (op_val[g])
    );
  end

  assign read_index_1  = in_ready ? in_rs1 : held_idx[0];
  assign read_index_2  = in_ready ? in_rs2 : held_idx[1];
  assign out_rs1_value = op_val[0];
  assign out_rs2_value = op_val[1];
  assign out_tag       = tag_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register file model plus an architectural reference
// (operands equal current register contents while an instruction is pending).
module tb_operand_fetch;
  localparam int TW = 32;
`ifdef OPERAND_FETCH_LIVE_BYPASS_EN
  localparam bit LIVE = 1'b1;
`else
  localparam bit LIVE = 1'b0;
`endif

  logic          clk = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic          out_ready = 1'b0, write_enabled = 1'b0;
  logic [4:0]    in_rs1 = '0, in_rs2 = '0, write_index = '0;
  logic [TW-1:0] in_tag = '0;
  logic [31:0]   write_value = '0;
  logic          in_ready, out_valid;
  logic [4:0]    read_index_1, read_index_2;
  logic [31:0]   read1_value, read2_value, out_rs1_value, out_rs2_value;
  logic [TW-1:0] out_tag;

  logic [31:0]   rf [32];
  int            n_cmp = 0, n_err = 0;
  logic          m_valid;
  logic [4:0]    m_rs1, m_rs2;
  logic [TW-1:0] m_tag;

  operand_fetch #(.TAG_WIDTH(TW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .read_index_1(read_index_1), .read_index_2(read_index_2),
    .read1_value(read1_value), .read2_value(read2_value),
    .write_enabled(write_enabled), .write_index(write_index), .write_value(write_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Register file: synchronous read returns pre-write contents on a write edge.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (write_enabled && write_index != 0) begin
      rf[write_index] <= write_value;
    end
    read1_value <= rf[read_index_1];
    read2_value <= rf[read_index_2];
  end

  // Reference: which instruction is pending, nothing about how it is stored.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_valid <= 1'b0;
    else if (flush) m_valid <= 1'b0;
    else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1; m_rs1 <= in_rs1; m_rs2 <= in_rs2; m_tag <= in_tag;
    end else if (out_ready) m_valid <= 1'b0;
  end

  function automatic logic [31:0] exp_op(input logic [4:0] r);
    if (!m_valid || r == 0) return '0;
    if (LIVE && write_enabled && write_index == r) return write_value;
    return rf[r];
  endfunction

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [TW-1:0] t, input logic ordy, input logic fl,
                       input logic we, input logic [4:0] wi, input logic [31:0] wv);
    @(negedge clk);
    in_valid = v; in_rs1 = r1; in_rs2 = r2; in_tag = t; out_ready = ordy; flush = fl;
    write_enabled = we; write_index = wi; write_value = wv;
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_rs1_value !== 32'h0 || out_rs2_value !== 32'h0)
      begin n_err++; $display("FAIL reset_ops got %h/%h want 0/0", out_rs1_value, out_rs2_value); end
    n_cmp++; if (out_tag !== '0) begin n_err++; $display("FAIL reset_tag got %h want 0", out_tag); end
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    drive(0, 0, 0, 0, 1, 0, 1, 5, 32'h11);
    drive(0, 0, 0, 0, 1, 0, 1, 6, 32'h22);
    drive(1, 5, 6, 32'h100, 1, 0, 0, 0, 0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready got %0b want 1", in_ready); end
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    n_cmp++; if (out_valid !== 1'b1 || out_tag !== 32'h100)
      begin n_err++; $display("FAIL basic_valid_tag got %0b/%h want 1/100", out_valid, out_tag); end
    n_cmp++; if (out_rs1_value !== 32'h11 || out_rs2_value !== 32'h22)
      begin n_err++; $display("FAIL basic_ops got %h/%h want 11/22", out_rs1_value, out_rs2_value); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready2 got %0b want 1", in_ready); end
  endtask

  task automatic test_stale();
    drive(1, 7, 0, 32'h7, 1, 0, 1, 7, 32'hDEAD);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    n_cmp++; if (out_valid !== 1'b1 || out_rs1_value !== 32'hDEAD)
      begin n_err++; $display("FAIL stale_rs1 got %0b/%h want 1/dead", out_valid, out_rs1_value); end
  endtask

  task automatic test_backpressure();
    drive(0, 0, 0, 0, 1, 0, 1, 3, 32'h1);
    drive(1, 3, 3, 32'h33, 0, 0, 0, 0, 0);
    for (int h = 0; h < 3; h++) begin
      drive(1, 9, 9, 32'h99, 0, 0, (h < 2), 3, (h == 0) ? 32'h2 : 32'h3);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d] got %0b want 0", h, in_ready); end
      n_cmp++; if (out_rs1_value !== exp_op(3) || out_rs2_value !== exp_op(3))
        begin n_err++; $display("FAIL hold_ops[%0d] got %h/%h want %h", h, out_rs1_value, out_rs2_value, exp_op(3)); end
    end
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    n_cmp++; if (out_valid !== 1'b1 || out_rs1_value !== 32'h3 || out_rs2_value !== 32'h3 || out_tag !== 32'h33)
      begin n_err++; $display("FAIL release_ops got %0b %h/%h tag %h want 1 3/3 tag 33",
                              out_valid, out_rs1_value, out_rs2_value, out_tag); end
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_x0();
    drive(1, 0, 0, 32'h0, 1, 0, 1, 0, 32'hFFFF_FFFF);
    drive(0, 0, 0, 0, 1, 0, 1, 0, 32'hFFFF_FFFF);
    n_cmp++; if (out_valid !== 1'b1 || out_rs1_value !== 32'h0 || out_rs2_value !== 32'h0)
      begin n_err++; $display("FAIL x0_ops got %0b %h/%h want 1 0/0", out_valid, out_rs1_value, out_rs2_value); end
  endtask

  task automatic test_back_to_back_flush();
    for (int i = 0; i < 6; i++) begin
      drive(1, 5'(i + 1), 5'(i + 2), TW'(i), 1, (i == 3), 0, 0, 0);
      n_cmp++; if (in_ready !== (i != 3)) begin n_err++; $display("FAIL b2b_ready[%0d] got %0b want %0b", i, in_ready, (i != 3)); end
      if (i == 4) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0b want 0", out_valid); end
      end else if (i > 0) begin
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== TW'(i - 1))
          begin n_err++; $display("FAIL b2b_tag[%0d] got %0b/%h want 1/%h", i, out_valid, out_tag, i - 1); end
      end
    end
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    n_cmp++; if (out_valid !== 1'b1 || out_tag !== TW'(5) || out_rs1_value !== exp_op(6) || out_rs2_value !== exp_op(7))
      begin n_err++; $display("FAIL resume got %0b tag %h ops %h/%h", out_valid, out_tag, out_rs1_value, out_rs2_value); end
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_live_bypass();
    drive(0, 0, 0, 0, 1, 0, 1, 4, 32'h10);
    drive(1, 4, 0, 32'h4, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1, 4, 32'h55);
    n_cmp++; if (out_valid !== 1'b1 || out_rs1_value !== (LIVE ? 32'h55 : 32'h10))
      begin n_err++; $display("FAIL live_bypass got %0b/%h want 1/%h", out_valid, out_rs1_value, LIVE ? 32'h55 : 32'h10); end
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), TW'($urandom),
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom);
      n_cmp++; if (in_ready !== (!flush && (!m_valid || out_ready)) || out_valid !== m_valid)
        begin n_err++; $display("FAIL rnd_hs[%0d] ready %0b valid %0b want valid %0b", c, in_ready, out_valid, m_valid); end
      if (in_ready === 1'b1) begin
        n_cmp++; if (read_index_1 !== in_rs1 || read_index_2 !== in_rs2)
          begin n_err++; $display("FAIL rnd_idx[%0d] got %0d/%0d want %0d/%0d", c, read_index_1, read_index_2, in_rs1, in_rs2); end
      end
      if (m_valid) begin
        n_cmp++; if (out_rs1_value !== exp_op(m_rs1) || out_rs2_value !== exp_op(m_rs2) || out_tag !== m_tag)
          begin n_err++; $display("FAIL rnd_ops[%0d] got %h/%h tag %h want %h/%h tag %h", c, out_rs1_value,
                                  out_rs2_value, out_tag, exp_op(m_rs1), exp_op(m_rs2), m_tag); end
      end
    end
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic test_reset_mid_hold();
    drive(0, 0, 0, 0, 1, 0, 1, 9, 32'h99);
    drive(1, 9, 9, 32'h9, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_valid got %0b want 0", out_valid); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_emit[%0d] got %0b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stale();
    test_backpressure();
    test_x0();
    test_back_to_back_flush();
    test_live_bypass();
    test_random();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Initiator side of the register file read interface.
- Accepts decoded instructions (rs1, rs2, tag) over a valid/ready handshake and drives the register file read indices.
- Absorbs the file's 1-cycle synchronous read latency and repairs same-edge write staleness by snooping the file's write port.
- Presents resolved operands downstream, holding them coherent under backpressure.
- Sits between decode and execute.

Parameters:
- TAG_WIDTH, 32, width of the opaque payload (e.g. PC) carried alongside the operands.
- XLEN, 32, register width; fixed at 32 to match the register file.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  reset.
- flush  input  1  synchronous discard of any accepted or held instruction.
- in_valid  input  1  decode offers an instruction.
- in_ready  output  1  this block accepts this cycle.
- in_rs1  input  5  source register index 1.
- in_rs2  input  5  source register index 2.
- in_tag  input  TAG_WIDTH  payload.
- read_index_1  output  5  to register file.
- read_index_2  output  5  to register file.
- read1_value  input  XLEN  from register file, 1 cycle after index.
- read2_value  input  XLEN  from register file.
- write_enabled  input  1  snooped copy of the register file write port.
- write_index  input  5  snooped write index.
- write_value  input  XLEN  snooped write data.
- out_valid  output  1  operands available.
- out_ready  input  1  execute consumes.
- out_rs1_value  output  XLEN  resolved operand 1.
- out_rs2_value  output  XLEN  resolved operand 2.
- out_tag  output  TAG_WIDTH  payload.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- **Reset (reset_n low, asynchronous):**
  - out_valid=0, out_rs1_value=0, out_rs2_value=0, out_tag=0, held indices=0, bypass flags=0.
  - in_ready=1 from the first cycle after release.
- **Handshake:**
  - Accept occurs when in_valid && in_ready at a posedge.
  - in_ready = !flush && (!out_valid || out_ready). This is a full-throughput single stage.
  - Emit occurs when out_valid && out_ready at a posedge.
  - Accept and emit on the same edge is legal; it gives 1 instruction per cycle.
- **Read indices:**
  - read_index_1/2 = in_rs1/in_rs2 while in_ready.
  - Otherwise they equal the held indices.
  - Values matter only on accept cycles.
- **Latency:** the instruction accepted at edge N has out_valid=1 in the cycle after N.
- **State machine (per stage):**
  - EMPTY: out_valid=0. Accept moves to FRESH.
  - FRESH: first valid cycle.
    - Operand = captured same-edge write value if its bypass flag is set, else readN_value.
    - Emit with a new accept stays in FRESH; emit without a new accept moves to EMPTY.
    - No emit moves to HELD; the resolved operand (after snoop, below) is latched.
  - HELD: operand comes from the internal register.
    - Emit with accept moves to FRESH; emit alone moves to EMPTY.
- **Same-edge write (stale read):** if write_enabled && write_index==in_rsN && write_index!=0 at the accept edge, set the bypass flag and capture write_value.
- **Snoop while FRESH/HELD:** a write at an edge where the instruction is not emitted, matching a held nonzero index, updates that operand. Both operands update if both indices match.
- **Write at the emit edge:** has no effect on the emitted operand. With the optional feature below, the live write is visible on the outputs.
- **Index 0:** the operand is always 0; never bypassed or snooped.
- **flush:**
  - out_valid=0 at the next edge; state becomes EMPTY.
  - Overrides the same-cycle accept (in_ready=0) and the emit-side register update.
- **Reset mid-operation:** the in-flight instruction is dropped silently; nothing is emitted after reset release.

Optional Feature:
- Macro: OPERAND_FETCH_LIVE_BYPASS_EN.
- **Defined:** out_rsN_value is combinationally replaced by write_value when out_valid && write_enabled && write_index==held rsN && rsN!=0 in the current cycle. Execute then sees writes retiring in the same cycle.
- **Undefined:** outputs reflect writes through the previous edge only; same-cycle hazards are the consumer's responsibility.

Decomposition:
- Shared package holds:
  - XLEN=32, REG_INDEX_WIDTH=5, ZERO_REG=5'd0.
  - The state enum {EMPTY, FRESH, HELD}.
- One natural sub-module, operand_slot: per-operand held index, bypass flag, value register and snoop/resolve logic. Instantiated twice.
- Handshake/FSM and tag register stay in the top.

Test Plan:
- Basic path:
  - Stimulus: register file holds x5=0x11, x6=0x22; accept rs1=5, rs2=6, tag=0x100, out_ready=1.
  - Required: next cycle out_valid=1, operands 0x11/0x22, tag 0x100; in_ready stays 1.
- Same-edge staleness:
  - Stimulus: accept rs1=7 while write x7=0xDEAD on the same edge; register file returns the old 0.
  - Required: out_rs1_value=0xDEAD.
- Backpressure snoop:
  - Stimulus: accept rs1=rs2=3 (x3=1), hold out_ready=0 for 3 cycles, writing x3=2 and then x3=3 during the hold.
  - Required: on release, both operands=3; in_ready=0 throughout the hold.
- x0:
  - Stimulus: accept rs1=0, rs2=0 while write_index=0, value 0xFFFF_FFFF, write_enabled=1.
  - Required: both operands 0.
- Back-to-back with flush:
  - Stimulus: stream accepts at 1/cycle with out_ready=1; assert flush with in_valid=1.
  - Required: that cycle in_ready=0; next cycle out_valid=0; the stream then resumes correctly.
- Reset mid-hold plus live bypass:
  - Stimulus: drop reset_n asynchronously while HELD.
  - Required: out_valid falls immediately, no emit after release.
  - With OPERAND_FETCH_LIVE_BYPASS_EN, a write to x4=0x55 in the FRESH cycle of rs1=4 shows 0x55 the same cycle; without the macro it does not.
